// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle CPU control unit
// Contents: FSM state encoding (IF = 0), opcode constants, ALUop constants,
// PCSrc encodings and the instruction class produced by ctrl_decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_EXE_BR = 4'd3,
        ST_EXE_LS = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_AL  = 4'd7,
        ST_WB_LD  = 4'd8,
        ST_HALT   = 4'd9
    } ctrlState;

    typedef enum logic [3:0] {
        CLS_R_ALU   = 4'd0,
        CLS_I_ALU   = 4'd1,
        CLS_SHIFT   = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_JUMP    = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instrClass;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_XNOR = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder for the control FSM
// Ports: op (in, OP_W) opcode; iClass (out) instruction class;
//        aluOp (out, 3) ALU operation; extSel (out) 1 = sign-extend;
//        branchNe (out) 1 = bne, branch taken on zero = 0.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output instrClass       iClass,
    output logic [2:0]      aluOp,
    output logic            extSel,
    output logic            branchNe
);

    always_comb begin
        iClass   = CLS_ILLEGAL;
        aluOp    = ALU_ADD;
        extSel   = 1'b0;
        branchNe = 1'b0;
        case (op)
            OP_W'(OP_ADD):   begin iClass = CLS_R_ALU; aluOp = ALU_ADD; end
            OP_W'(OP_SUB):   begin iClass = CLS_R_ALU; aluOp = ALU_SUB; end
            OP_W'(OP_ADDIU): begin iClass = CLS_I_ALU; aluOp = ALU_ADD; extSel = 1'b1; end
            OP_W'(OP_ANDI):  begin iClass = CLS_I_ALU; aluOp = ALU_AND; end
            OP_W'(OP_AND):   begin iClass = CLS_R_ALU; aluOp = ALU_AND; end
            OP_W'(OP_ORI):   begin iClass = CLS_I_ALU; aluOp = ALU_OR;  end
            OP_W'(OP_OR):    begin iClass = CLS_R_ALU; aluOp = ALU_OR;  end
            OP_W'(OP_SLL):   begin iClass = CLS_SHIFT; aluOp = ALU_SLL; end
            OP_W'(OP_SLTI):  begin iClass = CLS_I_ALU; aluOp = ALU_SLT; extSel = 1'b1; end
            OP_W'(OP_SW):    begin iClass = CLS_STORE; extSel = 1'b1; end
            OP_W'(OP_LW):    begin iClass = CLS_LOAD;  extSel = 1'b1; end
            OP_W'(OP_BEQ):   begin iClass = CLS_BRANCH; aluOp = ALU_SUB; extSel = 1'b1; end
            OP_W'(OP_BNE):   begin iClass = CLS_BRANCH; aluOp = ALU_SUB; extSel = 1'b1; branchNe = 1'b1; end
            OP_W'(OP_J):     iClass = CLS_JUMP;
            OP_W'(OP_HALT):  iClass = CLS_HALT;
            default:         iClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB)
// Ports: CLK, Reset (sync, active-high); Op opcode; zero ALU flag;
//        MemReady memory handshake; PCWre, IRWre, ALUSrcA, ALUSrcB, ALUop,
//        ExtSel, RegWre, RegDst, DBDataSrc, mRD, mWR, PCSrc datapath controls;
//        Halted core stopped; State debug; IllegalOp (CTRL_ILLEGAL_TRAP_EN only).
// Macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the core instead of
// retiring as a NOP.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] Op,
    input  logic            zero,
    input  logic            MemReady,
    output logic            PCWre,
    output logic            IRWre,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic [2:0]      ALUop,
    output logic            ExtSel,
    output logic            RegWre,
    output logic            RegDst,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic [1:0]      PCSrc,
    output logic            Halted,
    output logic [3:0]      State
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic            IllegalOp
`endif
);

    ctrlState  state;
    ctrlState  nextState;
    instrClass iClass;
    logic [2:0] decAluOp;
    logic       decExtSel;
    logic       branchNe;

    ctrl_decode #(.OP_W(OP_W)) uDecode (
        .op       (Op),
        .iClass   (iClass),
        .aluOp    (decAluOp),
        .extSel   (decExtSel),
        .branchNe (branchNe)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IF;
        end else begin
            state <= nextState;
        end
    end

    assign State = state;

    always_comb begin
        nextState = state;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUop     = ALU_ADD;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PC_NEXT;
        Halted    = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        IllegalOp = 1'b0;
`endif
        case (state)
            ST_IF: begin
                IRWre     = 1'b1;
                nextState = ST_ID;
            end
            ST_ID: begin
                case (iClass)
                    CLS_R_ALU, CLS_I_ALU, CLS_SHIFT: nextState = ST_EXE_AL;
                    CLS_BRANCH:                      nextState = ST_EXE_BR;
                    CLS_LOAD, CLS_STORE:             nextState = ST_EXE_LS;
                    CLS_JUMP: begin
                        // Jumps retire here, so this is their only PC load.
                        PCWre     = 1'b1;
                        PCSrc     = PC_JUMP;
                        nextState = ST_IF;
                    end
                    CLS_HALT:                        nextState = ST_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        IllegalOp = 1'b1;
                        nextState = ST_HALT;
`else
                        PCWre     = 1'b1;
                        PCSrc     = PC_NEXT;
                        nextState = ST_IF;
`endif
                    end
                endcase
            end
            // WB_AL keeps the EXE_AL ALU controls so the result stays valid
            // while it is written back.
            ST_EXE_AL, ST_WB_AL: begin
                ALUop   = decAluOp;
                ExtSel  = decExtSel;
                ALUSrcA = (iClass == CLS_SHIFT);
                ALUSrcB = (iClass == CLS_I_ALU);
                if (state == ST_WB_AL) begin
                    RegWre    = 1'b1;
                    RegDst    = (iClass == CLS_R_ALU) || (iClass == CLS_SHIFT);
                    PCWre     = 1'b1;
                    nextState = ST_IF;
                end else begin
                    nextState = ST_WB_AL;
                end
            end
            ST_EXE_BR: begin
                ALUop  = ALU_SUB;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                // beq takes on zero = 1, bne on zero = 0.
                PCSrc     = (zero ^ branchNe) ? PC_BRANCH : PC_NEXT;
                nextState = ST_IF;
            end
            // Address computation stays driven through the memory access and
            // load writeback.
            ST_EXE_LS, ST_MEM_RD, ST_MEM_WR, ST_WB_LD: begin
                ALUop   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                case (state)
                    ST_EXE_LS: nextState = (iClass == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                    ST_MEM_RD: begin
                        mRD = 1'b1;
                        if (MemReady) begin
                            nextState = ST_WB_LD;
                        end
                    end
                    ST_MEM_WR: begin
                        mWR = 1'b1;
                        if (MemReady) begin
                            PCWre     = 1'b1;
                            nextState = ST_IF;
                        end
                    end
                    default: begin
                        RegWre    = 1'b1;
                        DBDataSrc = 1'b1;
                        PCWre     = 1'b1;
                        nextState = ST_IF;
                    end
                endcase
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: nextState = ST_IF;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard testbench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;
    import ctrl_pkg::*;

    logic       CLK;
    logic       Reset;
    logic [5:0] Op;
    logic       zero;
    logic       MemReady;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, RegDst;
    logic       DBDataSrc, mRD, mWR, Halted;
    logic [2:0] ALUop;
    logic [1:0] PCSrc;
    logic [3:0] State;
    logic       illegalObs;

    multi_cycle_ctrl #(.OP_W(6)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Op        (Op),
        .zero      (zero),
        .MemReady  (MemReady),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUop     (ALUop),
        .ExtSel    (ExtSel),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .DBDataSrc (DBDataSrc),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .Halted    (Halted),
        .State     (State)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .IllegalOp (illegalObs)
`endif
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign illegalObs = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       irWre;
        logic       pcWre;
        logic [1:0] pcSrc;
        logic       srcA;
        logic       srcB;
        logic [2:0] aluOp;
        logic       ext;
        logic       regWre;
        logic       regDst;
        logic       dbSrc;
        logic       mRd;
        logic       mWr;
        logic       halted;
        logic       illegal;
    } obsT;

    typedef struct packed {
        obsT        exp;
        logic [5:0] op;
        logic       z;
        logic       rdy;
    } recT;

    localparam int K_R = 0, K_I = 1, K_BR = 2, K_LW = 3, K_SW = 4, K_J = 5, K_HALT = 6, K_ILL = 7;

    obsT act;
    assign act = {State, IRWre, PCWre, PCSrc, ALUSrcA, ALUSrcB, ALUop, ExtSel,
                  RegWre, RegDst, DBDataSrc, mRD, mWR, Halted, illegalObs};

    recT sb[$];
    int  checks = 0;
    int  failures = 0;

    function automatic obsT base(input logic [3:0] st);
        obsT e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Opcode table: class, ALUop, extension, shift flag.
    task automatic opInfo(input logic [5:0] op, output int k, output logic [2:0] alu,
                          output logic ext, output logic sh);
        k = K_ILL; alu = 3'b000; ext = 1'b0; sh = 1'b0;
        case (op)
            6'b000000: begin k = K_R; alu = 3'b000; end
            6'b000001: begin k = K_R; alu = 3'b001; end
            6'b000010: begin k = K_I; alu = 3'b000; ext = 1'b1; end
            6'b010000: begin k = K_I; alu = 3'b100; end
            6'b010001: begin k = K_R; alu = 3'b100; end
            6'b010010: begin k = K_I; alu = 3'b011; end
            6'b010011: begin k = K_R; alu = 3'b011; end
            6'b011000: begin k = K_R; alu = 3'b010; sh = 1'b1; end
            6'b011100: begin k = K_I; alu = 3'b110; ext = 1'b1; end
            6'b100110: k = K_SW;
            6'b100111: k = K_LW;
            6'b110000: k = K_BR;
            6'b110001: k = K_BR;
            6'b111000: k = K_J;
            6'b111111: k = K_HALT;
            default:   k = K_ILL;
        endcase
    endtask

    task automatic push(input obsT e, input logic [5:0] op, input logic z, input logic rdy);
        recT r;
        r.exp = e; r.op = op; r.z = z; r.rdy = rdy;
        sb.push_back(r);
    endtask

    // Pushes the expected cycle-by-cycle trace of one instruction.
    task automatic pushInstr(input logic [5:0] op, input logic z, input int waits);
        obsT e;
        int k;
        logic [2:0] alu;
        logic ext, sh;
        opInfo(op, k, alu, ext, sh);
        e = base(ST_IF); e.irWre = 1'b1;
        push(e, op, rbit(), rbit());
        e = base(ST_ID);
        case (k)
            K_J: begin e.pcWre = 1'b1; e.pcSrc = 2'b10; push(e, op, rbit(), rbit()); end
            K_HALT: push(e, op, rbit(), rbit());
            K_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                e.illegal = 1'b1;
`else
                e.pcWre = 1'b1;
`endif
                push(e, op, rbit(), rbit());
            end
            K_R, K_I: begin
                push(e, op, rbit(), rbit());
                e = base(ST_EXE_AL);
                e.aluOp = alu; e.ext = ext; e.srcA = sh; e.srcB = (k == K_I);
                push(e, op, rbit(), rbit());
                e.st = ST_WB_AL; e.regWre = 1'b1; e.regDst = (k == K_R); e.pcWre = 1'b1;
                push(e, op, rbit(), rbit());
            end
            K_BR: begin
                push(e, op, rbit(), rbit());
                e = base(ST_EXE_BR);
                e.aluOp = 3'b001; e.ext = 1'b1; e.pcWre = 1'b1;
                e.pcSrc = ((op == 6'b110000 && z) || (op == 6'b110001 && !z)) ? 2'b01 : 2'b00;
                push(e, op, z, rbit());
            end
            default: begin
                push(e, op, rbit(), rbit());
                e = base(ST_EXE_LS);
                e.srcB = 1'b1; e.ext = 1'b1;
                push(e, op, rbit(), rbit());
                if (k == K_LW) begin e.st = ST_MEM_RD; e.mRd = 1'b1; end
                else begin e.st = ST_MEM_WR; e.mWr = 1'b1; end
                for (int i = 0; i < waits; i++) push(e, op, rbit(), 1'b0);
                if (k == K_SW) e.pcWre = 1'b1;
                push(e, op, rbit(), 1'b1);
                if (k == K_LW) begin
                    e.st = ST_WB_LD; e.mRd = 1'b0;
                    e.regWre = 1'b1; e.dbSrc = 1'b1; e.pcWre = 1'b1;
                    push(e, op, rbit(), rbit());
                end
            end
        endcase
    endtask

    task automatic test_reset();
        obsT e;
        Reset = 1'b1; Op = 6'b111111; zero = 1'b1; MemReady = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        e = base(ST_IF); e.irWre = 1'b1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL reset actual=%h required=%h", act, e);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    task automatic test_add();
        recT r;
        int pulses = 0, n = 0;
        pushInstr(6'b000000, 1'b0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL add cycle=%0d actual=%h required=%h", n, act, r.exp);
            end
            pulses += int'(PCWre);
            n++;
            @(posedge CLK); #1;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL add_pcwre_pulses actual=%0d required=1", pulses);
        end
    endtask

    task automatic test_alu_ops();
        recT r;
        logic [5:0] ops [8] = '{6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                6'b010010, 6'b010011, 6'b011000, 6'b011100};
        int n = 0;
        foreach (ops[i]) pushInstr(ops[i], 1'b0, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL alu_ops op=%b cycle=%0d actual=%h required=%h", r.op, n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        recT r;
        int n = 0;
        pushInstr(6'b110000, 1'b1, 0);
        pushInstr(6'b110000, 1'b0, 0);
        pushInstr(6'b110001, 1'b0, 0);
        pushInstr(6'b110001, 1'b1, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL branch op=%b z=%b cycle=%0d actual=%h required=%h", r.op, r.z, n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mem();
        recT r;
        int n = 0, rdCycles = 0;
        pushInstr(6'b100111, 1'b0, 3);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL lw_wait cycle=%0d actual=%h required=%h", n, act, r.exp);
            end
            rdCycles += int'(mRD);
            n++;
            @(posedge CLK); #1;
        end
        checks++;
        if (rdCycles !== 4 || n !== 8 || State !== 4'(ST_IF)) begin
            failures++;
            $display("FAIL lw_latency mrd=%0d cycles=%0d state=%0d required mrd=4 cycles=8 state=0",
                     rdCycles, n, State);
        end
        pushInstr(6'b100111, 1'b0, 0);
        pushInstr(6'b100110, 1'b0, 0);
        pushInstr(6'b100110, 1'b1, 2);
        n = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL mem op=%b cycle=%0d actual=%h required=%h", r.op, n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        recT r;
        int n = 0;
        pushInstr(6'b111000, 1'b0, 0);
        pushInstr(6'b000000, 1'b0, 0);
        pushInstr(6'b100110, 1'b0, 1);
        pushInstr(6'b110000, 1'b1, 0);
        pushInstr(6'b100111, 1'b0, 1);
        pushInstr(6'b011100, 1'b0, 0);
        pushInstr(6'b111000, 1'b1, 0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL back_to_back op=%b cycle=%0d actual=%h required=%h", r.op, n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        recT r;
        obsT e;
        int n = 0;
        pushInstr(6'b111111, 1'b0, 0);
        e = base(ST_HALT); e.halted = 1'b1;
        for (int i = 0; i < 20; i++) push(e, 6'b111111, rbit(), rbit());
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL halt cycle=%0d actual=%h required=%h", n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        e = base(ST_IF); e.irWre = 1'b1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL halt_reset actual=%h required=%h", act, e);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        recT r;
        obsT e;
        int n = 0;
        pushInstr(6'b100110, 1'b0, 2);
        void'(sb.pop_back());
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL mid_wait cycle=%0d actual=%h required=%h", n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
        Reset = 1'b1; MemReady = 1'b0;
        @(negedge CLK);
        e = base(ST_MEM_WR); e.srcB = 1'b1; e.ext = 1'b1; e.mWr = 1'b1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL mid_wait_pre actual=%h required=%h", act, e);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        e = base(ST_IF); e.irWre = 1'b1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL mid_wait_reset actual=%h required=%h", act, e);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    task automatic test_illegal();
        recT r;
        obsT e;
        int n = 0;
        pushInstr(6'b101010, 1'b0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        e = base(ST_HALT); e.halted = 1'b1;
        for (int i = 0; i < 3; i++) push(e, 6'b101010, rbit(), rbit());
`else
        pushInstr(6'b000001, 1'b0, 0);
`endif
        while (sb.size() > 0) begin
            r = sb.pop_front();
            Op = r.op; zero = r.z; MemReady = r.rdy;
            @(negedge CLK);
            checks++;
            if (act !== r.exp) begin
                failures++;
                $display("FAIL illegal cycle=%0d actual=%h required=%h", n, act, r.exp);
            end
            n++;
            @(posedge CLK); #1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        Reset = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        e = base(ST_IF); e.irWre = 1'b1;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL illegal_reset actual=%h required=%h", act, e);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
`endif
    endtask

    initial begin
        Reset = 1'b1; Op = '0; zero = 1'b0; MemReady = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_mem();
        test_back_to_back();
        test_reset_mid_wait();
        test_illegal();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
